// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use stall
//
// Captures the decoded ID instruction each cycle and presents ALU-ready
// operands to EX, forwarding from MEM/WB and bypassing WB at capture time.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   id_*                          decoded instruction fields from ID
//   flush                         kill the ID instruction (taken branch/jump in EX)
//   mem_rd/mem_reg_write/mem_result  producer currently in MEM
//   wb_rd/wb_reg_write/wb_result     producer currently in WB
//   ex_valid, ex_pc, ex_rd, ex_alu_op  registered instruction info for EX
//   ex_alu_a, ex_alu_b            forwarded/selected ALU operands
//   ex_store_data                 forwarded rs2 value for stores
//   ex_reg_write/ex_mem_read/ex_mem_write  control, zero when ex_valid=0
//   stall_id                      freeze PC and IF/ID this cycle
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic [31:0] id_imm,
    input  logic [3:0]  id_alu_op,
    input  logic        id_src_a_pc,
    input  logic        id_src_b_imm,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic        flush,
    input  logic [4:0]  mem_rd,
    input  logic        mem_reg_write,
    input  logic [31:0] mem_result,
    input  logic [4:0]  wb_rd,
    input  logic        wb_reg_write,
    input  logic [31:0] wb_result,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [4:0]  ex_rd,
    output logic [3:0]  ex_alu_op,
    output logic [31:0] ex_alu_a,
    output logic [31:0] ex_alu_b,
    output logic [31:0] ex_store_data,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        stall_id
);

    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic [31:0] rs1_val_q;
    logic [31:0] rs2_val_q;
    logic [31:0] imm_q;
    logic        src_a_pc_q;
    logic        src_b_imm_q;

    logic [31:0] rs1_cap;
    logic [31:0] rs2_cap;
    logic [31:0] fwd_rs1;
    logic [31:0] fwd_rs2;
    logic        bubble;

    // A load in EX whose destination is read by ID cannot be forwarded in
    // time; both rs fields are compared regardless of format (over-stall is harmless).
    assign stall_id = id_valid & ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                      ((ex_rd == id_rs1) | (ex_rd == id_rs2)) & ~flush;

    assign bubble = flush | stall_id;

    // The register file is not write-through, so a value being written back
    // this cycle must be picked up here or it would be lost.
    assign rs1_cap = (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == id_rs1)) ? wb_result : id_rs1_data;
    assign rs2_cap = (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == id_rs2)) ? wb_result : id_rs2_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_pc        <= 32'd0;
            ex_rd        <= 5'd0;
            ex_alu_op    <= 4'd0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            rs1_q        <= 5'd0;
            rs2_q        <= 5'd0;
            rs1_val_q    <= 32'd0;
            rs2_val_q    <= 32'd0;
            imm_q        <= 32'd0;
            src_a_pc_q   <= 1'b0;
            src_b_imm_q  <= 1'b0;
        end else if (bubble) begin
            ex_valid     <= 1'b0;
            ex_pc        <= 32'd0;
            ex_rd        <= 5'd0;
            ex_alu_op    <= 4'd0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            rs1_q        <= 5'd0;
            rs2_q        <= 5'd0;
            rs1_val_q    <= 32'd0;
            rs2_val_q    <= 32'd0;
            imm_q        <= 32'd0;
            src_a_pc_q   <= 1'b0;
            src_b_imm_q  <= 1'b0;
        end else begin
            ex_valid     <= id_valid;
            ex_pc        <= id_pc;
            ex_rd        <= id_rd;
            ex_alu_op    <= id_alu_op;
            // Control is qualified by valid so a non-instruction never writes.
            ex_reg_write <= id_valid & id_reg_write;
            ex_mem_read  <= id_valid & id_mem_read;
            ex_mem_write <= id_valid & id_mem_write;
            rs1_q        <= id_rs1;
            rs2_q        <= id_rs2;
            rs1_val_q    <= rs1_cap;
            rs2_val_q    <= rs2_cap;
            imm_q        <= id_imm;
            src_a_pc_q   <= id_src_a_pc;
            src_b_imm_q  <= id_src_b_imm;
        end
    end

    // MEM holds the younger producer, so it wins over WB; x0 is never forwarded.
    always_comb begin
        fwd_rs1 = rs1_val_q;
        if (rs1_q != 5'd0) begin
            if (mem_reg_write && (mem_rd == rs1_q)) begin
                fwd_rs1 = mem_result;
            end else if (wb_reg_write && (wb_rd == rs1_q)) begin
                fwd_rs1 = wb_result;
            end
        end
    end

    always_comb begin
        fwd_rs2 = rs2_val_q;
        if (rs2_q != 5'd0) begin
            if (mem_reg_write && (mem_rd == rs2_q)) begin
                fwd_rs2 = mem_result;
            end else if (wb_reg_write && (wb_rd == rs2_q)) begin
                fwd_rs2 = wb_result;
            end
        end
    end

    assign ex_alu_a      = src_a_pc_q  ? ex_pc : fwd_rs1;
    assign ex_alu_b      = src_b_imm_q ? imm_q : fwd_rs2;
    assign ex_store_data = fwd_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic [3:0]  id_alu_op;
    logic        id_src_a_pc, id_src_b_imm;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic        flush;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic [31:0] mem_result;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] wb_result;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rd;
    logic [3:0]  ex_alu_op;
    logic [31:0] ex_alu_a, ex_alu_b, ex_store_data;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;
    logic        stall_id;

    int n_cmp = 0;
    int n_err = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_alu_op(id_alu_op),
        .id_src_a_pc(id_src_a_pc), .id_src_b_imm(id_src_b_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .flush(flush),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op),
        .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b), .ex_store_data(ex_store_data),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .stall_id(stall_id)
    );

    always #5 clk = ~clk;

    // Reference: the instruction that currently sits in EX, as the spec describes it.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] v1, v2, imm;
        logic [3:0]  op;
        logic        a_pc, b_imm, rw, mr, mw;
    } ex_t;

    ex_t m;

    function automatic logic model_stall();
        // Load in EX feeding an operand of the real instruction in ID.
        return id_valid && m.valid && m.mr && m.rd != 0 &&
               (m.rd == id_rs1 || m.rd == id_rs2) && !flush;
    endfunction

    function automatic logic [31:0] reg_value(input logic [4:0] rs, input logic [31:0] held);
        if (rs == 0) return held;
        if (mem_reg_write && mem_rd == rs) return mem_result;
        if (wb_reg_write && wb_rd == rs) return wb_result;
        return held;
    endfunction

    function automatic logic [31:0] read_at_id(input logic [4:0] rs, input logic [31:0] rf);
        if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return wb_result;
        return rf;
    endfunction

    task automatic tick();
        ex_t nxt;
        nxt = '0;
        if (rst_n && !flush && !model_stall()) begin
            nxt.valid = id_valid;
            nxt.pc    = id_pc;
            nxt.rs1   = id_rs1;
            nxt.rs2   = id_rs2;
            nxt.rd    = id_rd;
            nxt.v1    = read_at_id(id_rs1, id_rs1_data);
            nxt.v2    = read_at_id(id_rs2, id_rs2_data);
            nxt.imm   = id_imm;
            nxt.op    = id_alu_op;
            nxt.a_pc  = id_src_a_pc;
            nxt.b_imm = id_src_b_imm;
            nxt.rw    = id_valid && id_reg_write;
            nxt.mr    = id_valid && id_mem_read;
            nxt.mw    = id_valid && id_mem_write;
        end
        @(posedge clk);
        #1;
        m = nxt;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_alu_op = 0;
        id_src_a_pc = 0; id_src_b_imm = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        flush = 0;
        mem_rd = 0; mem_reg_write = 0; mem_result = 0;
        wb_rd = 0; wb_reg_write = 0; wb_result = 0;
    endtask

    task automatic id_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] d1,
                          input logic [4:0] rs2, input logic [31:0] d2);
        id_valid = 1; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        id_rs1_data = d1; id_rs2_data = d2; id_alu_op = 4'b0000;
        id_src_a_pc = 0; id_src_b_imm = 0; id_imm = 0;
        id_reg_write = 1; id_mem_read = 0; id_mem_write = 0;
    endtask

    task automatic id_lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] d1);
        id_valid = 1; id_rd = rd; id_rs1 = rs1; id_rs2 = 0;
        id_rs1_data = d1; id_rs2_data = 0; id_alu_op = 4'b0000;
        id_src_a_pc = 0; id_src_b_imm = 1; id_imm = 32'd4;
        id_reg_write = 1; id_mem_read = 1; id_mem_write = 0;
    endtask

    task automatic test_reset();
        logic [141:0] all_out;
        idle_inputs();
        id_lw(5'd5, 5'd2, 32'h100);
        tick();
        id_add(5'd6, 5'd5, 32'd0, 5'd1, 32'd3);
        #1;
        n_cmp++;
        if (stall_id !== 1'b1) begin
            n_err++; $display("FAIL reset_pre_stall: got %b want 1", stall_id);
        end
        #2;
        rst_n = 0;
        m = '0;
        #1;
        all_out = {ex_valid, ex_pc, ex_rd, ex_alu_op, ex_alu_a, ex_alu_b, ex_store_data,
                   ex_reg_write, ex_mem_read, ex_mem_write, stall_id};
        n_cmp++;
        if (all_out !== '0) begin
            n_err++; $display("FAIL reset_async_outputs: got %h want 0", all_out);
        end
        tick();
        #2;
        rst_n = 1;
        idle_inputs();
        id_add(5'd3, 5'd1, 32'd5, 5'd2, 32'd7);
        tick();
        idle_inputs();
        #1;
        n_cmp++;
        if ({ex_valid, ex_alu_a, ex_alu_b, ex_alu_op} !== {1'b1, 32'd5, 32'd7, 4'b0000}) begin
            n_err++;
            $display("FAIL reset_first_add: got v=%b a=%h b=%h op=%h want v=1 a=5 b=7 op=0",
                     ex_valid, ex_alu_a, ex_alu_b, ex_alu_op);
        end
    endtask

    task automatic test_mem_forward();
        idle_inputs();
        id_add(5'd8, 5'd3, 32'd1, 5'd4, 32'd2);
        tick();
        idle_inputs();
        mem_reg_write = 1; mem_rd = 3; mem_result = 32'h10;
        wb_reg_write = 1; wb_rd = 3; wb_result = 32'h20;
        #1;
        n_cmp++;
        if (ex_alu_a !== 32'h10) begin
            n_err++; $display("FAIL mem_fwd_priority: got %h want 00000010", ex_alu_a);
        end
        wb_rd = 4;
        #1;
        n_cmp++;
        if ({ex_alu_a, ex_alu_b} !== {32'h10, 32'h20}) begin
            n_err++; $display("FAIL mem_wb_split: got a=%h b=%h want a=10 b=20", ex_alu_a, ex_alu_b);
        end
        idle_inputs();
        id_add(5'd8, 5'd0, 32'd0, 5'd4, 32'd2);
        tick();
        idle_inputs();
        mem_reg_write = 1; mem_rd = 0; mem_result = 32'h10;
        wb_reg_write = 1; wb_rd = 0; wb_result = 32'h20;
        #1;
        n_cmp++;
        if (ex_alu_a !== 32'h0) begin
            n_err++; $display("FAIL x0_no_fwd: got %h want 0", ex_alu_a);
        end
    endtask

    task automatic test_load_use();
        idle_inputs();
        id_lw(5'd5, 5'd2, 32'h100);
        tick();
        id_add(5'd6, 5'd5, 32'd0, 5'd1, 32'd3);
        #1;
        n_cmp++;
        if (stall_id !== 1'b1) begin
            n_err++; $display("FAIL load_use_stall: got %b want 1", stall_id);
        end
        tick();
        mem_reg_write = 1; mem_rd = 5; mem_result = 32'h104;
        #1;
        n_cmp++;
        if ({ex_valid, ex_reg_write, stall_id} !== 3'b000) begin
            n_err++; $display("FAIL load_use_bubble: got v=%b rw=%b stall=%b want 000",
                              ex_valid, ex_reg_write, stall_id);
        end
        tick();
        mem_reg_write = 0; mem_rd = 0; mem_result = 0;
        wb_reg_write = 1; wb_rd = 5; wb_result = 32'hABCD;
        id_valid = 0;
        #1;
        n_cmp++;
        if ({ex_valid, ex_rd, ex_alu_a, ex_alu_b} !== {1'b1, 5'd6, 32'hABCD, 32'd3}) begin
            n_err++; $display("FAIL load_use_wb_fwd: got v=%b rd=%0d a=%h b=%h want v=1 rd=6 a=abcd b=3",
                              ex_valid, ex_rd, ex_alu_a, ex_alu_b);
        end
    endtask

    task automatic test_flush_vs_stall();
        idle_inputs();
        id_lw(5'd5, 5'd2, 32'h100);
        tick();
        id_add(5'd6, 5'd1, 32'd9, 5'd5, 32'd0);
        flush = 1;
        #1;
        n_cmp++;
        if (stall_id !== 1'b0) begin
            n_err++; $display("FAIL flush_beats_stall: got %b want 0", stall_id);
        end
        tick();
        flush = 0;
        id_valid = 0;
        #1;
        n_cmp++;
        if ({ex_valid, ex_reg_write, ex_mem_read, ex_rd} !== 8'd0) begin
            n_err++; $display("FAIL flush_bubble: got v=%b rw=%b mr=%b rd=%0d want 0",
                              ex_valid, ex_reg_write, ex_mem_read, ex_rd);
        end
    endtask

    task automatic test_wb_bypass();
        idle_inputs();
        id_add(5'd10, 5'd9, 32'd0, 5'd9, 32'd0);
        wb_reg_write = 1; wb_rd = 9; wb_result = 32'h55;
        tick();
        idle_inputs();
        #1;
        n_cmp++;
        if ({ex_alu_a, ex_alu_b} !== {32'h55, 32'h55}) begin
            n_err++; $display("FAIL wb_capture_bypass: got a=%h b=%h want 55 55", ex_alu_a, ex_alu_b);
        end
    endtask

    task automatic test_operand_select();
        idle_inputs();
        id_valid = 1; id_pc = 32'h100; id_src_a_pc = 1; id_src_b_imm = 1;
        id_imm = 32'hFFFFF800; id_rs1 = 1; id_rs1_data = 32'h11; id_rs2 = 7; id_rs2_data = 0;
        id_alu_op = 4'b1000; id_mem_write = 1;
        tick();
        idle_inputs();
        mem_reg_write = 1; mem_rd = 7; mem_result = 32'h77;
        #1;
        n_cmp++;
        if ({ex_alu_a, ex_alu_b, ex_store_data} !== {32'h100, 32'hFFFFF800, 32'h77}) begin
            n_err++; $display("FAIL operand_select: got a=%h b=%h sd=%h want 100 fffff800 77",
                              ex_alu_a, ex_alu_b, ex_store_data);
        end
        n_cmp++;
        if ({ex_mem_write, ex_reg_write, ex_alu_op} !== {1'b1, 1'b0, 4'b1000}) begin
            n_err++; $display("FAIL operand_select_ctrl: got mw=%b rw=%b op=%h want 1 0 8",
                              ex_mem_write, ex_reg_write, ex_alu_op);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            id_valid     = ($urandom_range(0, 9) != 0);
            id_pc        = $urandom;
            id_rs1       = 5'($urandom_range(0, 7));
            id_rs2       = 5'($urandom_range(0, 7));
            id_rd        = 5'($urandom_range(0, 7));
            id_rs1_data  = $urandom;
            id_rs2_data  = $urandom;
            id_imm       = $urandom;
            id_alu_op    = 4'($urandom_range(0, 8));
            id_src_a_pc  = $urandom_range(0, 1);
            id_src_b_imm = $urandom_range(0, 1);
            id_reg_write = $urandom_range(0, 1);
            id_mem_read  = ($urandom_range(0, 2) == 0);
            id_mem_write = ($urandom_range(0, 3) == 0);
            flush        = ($urandom_range(0, 7) == 0);
            mem_rd       = 5'($urandom_range(0, 7));
            mem_reg_write = $urandom_range(0, 1);
            mem_result   = $urandom;
            wb_rd        = 5'($urandom_range(0, 7));
            wb_reg_write = $urandom_range(0, 1);
            wb_result    = $urandom;
            #1;
            n_cmp++;
            if (stall_id !== model_stall()) begin
                n_err++; $display("FAIL rnd_stall[%0d]: got %b want %b", i, stall_id, model_stall());
            end
            n_cmp++;
            if ({ex_valid, ex_pc, ex_rd, ex_alu_op, ex_reg_write, ex_mem_read, ex_mem_write} !==
                {m.valid, m.pc, m.rd, m.op, m.rw, m.mr, m.mw}) begin
                n_err++; $display("FAIL rnd_fields[%0d]: got v=%b pc=%h rd=%0d op=%h c=%b%b%b want v=%b pc=%h rd=%0d op=%h c=%b%b%b",
                                  i, ex_valid, ex_pc, ex_rd, ex_alu_op, ex_reg_write, ex_mem_read, ex_mem_write,
                                  m.valid, m.pc, m.rd, m.op, m.rw, m.mr, m.mw);
            end
            n_cmp++;
            if (ex_alu_a !== (m.a_pc ? m.pc : reg_value(m.rs1, m.v1))) begin
                n_err++; $display("FAIL rnd_alu_a[%0d]: got %h want %h", i, ex_alu_a,
                                  m.a_pc ? m.pc : reg_value(m.rs1, m.v1));
            end
            n_cmp++;
            if (ex_alu_b !== (m.b_imm ? m.imm : reg_value(m.rs2, m.v2))) begin
                n_err++; $display("FAIL rnd_alu_b[%0d]: got %h want %h", i, ex_alu_b,
                                  m.b_imm ? m.imm : reg_value(m.rs2, m.v2));
            end
            n_cmp++;
            if (ex_store_data !== reg_value(m.rs2, m.v2)) begin
                n_err++; $display("FAIL rnd_store[%0d]: got %h want %h", i, ex_store_data,
                                  reg_value(m.rs2, m.v2));
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 0;
        m = '0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1;
        test_reset();
        test_mem_forward();
        test_load_use();
        test_flush_vs_stall();
        test_wb_bypass();
        test_operand_select();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with operand forwarding and load-use hazard detection for the 5-stage RV32I pipeline. Captures decoded instructions from ID each cycle and presents ALU-ready operands to the EX-stage ALU: `ex_alu_a`, `ex_alu_b` and the 4-bit `ex_alu_op`, using the ALU op encoding (add=0000 … sra=0111, U-pass-b=1000). It also carries control and `rd` downstream to EX/MEM, and emits the stall that freezes IF/ID.

## Interface
- No parameters. XLEN fixed at 32; register index width fixed at 5.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  32  PC of ID instruction.
- id_rs1, id_rs2, id_rd  in  5 each  register indices.
- id_rs1_data, id_rs2_data  in  32 each  register-file read data.
- id_imm  in  32  sign-extended immediate.
- id_alu_op  in  4  ALU op code.
- id_src_a_pc  in  1  select PC as operand A.
- id_src_b_imm  in  1  select imm as operand B.
- id_reg_write, id_mem_read, id_mem_write  in  1 each  control.
- flush  in  1  taken branch/jump resolved in EX; kill ID instruction.
- mem_rd  in  5  destination of the instruction in MEM.
- mem_reg_write  in  1  write enable of the instruction in MEM.
- mem_result  in  32  ALU result of the instruction in MEM.
- wb_rd  in  5  destination of the instruction in WB.
- wb_reg_write  in  1  write enable of the instruction in WB.
- wb_result  in  32  final writeback value.
- ex_valid  out  1  EX holds a real instruction.
- ex_pc  out  32  PC of EX instruction.
- ex_rd  out  5  destination index.
- ex_alu_op  out  4  ALU op code.
- ex_alu_a, ex_alu_b  out  32 each  ALU operands.
- ex_store_data  out  32  forwarded rs2 value.
- ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  control, qualified by valid.
- stall_id  out  1  hold PC and IF/ID this cycle.

## Operation
- Registered fields: valid, pc, rs1, rs2, rd, rs1_val, rs2_val, imm, alu_op, src_a_pc, src_b_imm, reg_write, mem_read, mem_write.
- Load-use detect (combinational):
  - `stall_id = id_valid & ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2) & ~flush`.
  - Compares against both rs fields regardless of instruction format. Over-stall on false matches is acceptable.
- Per edge, priority order:
  - If flush or stall_id: load a bubble. valid, reg_write, mem_read, mem_write, rs1, rs2 and rd are all set to 0; other fields are don't-care and are zeroed.
  - Otherwise capture all ID fields.
  - With id_valid=0, the captured valid, reg_write, mem_read and mem_write are 0.
- Capture-time WB bypass (register file is not write-through):
  - If `wb_reg_write & wb_rd!=0 & wb_rd==id_rs1`, capture wb_result into rs1_val instead of id_rs1_data. Same rule for rs2.
- EX-time forwarding (combinational, per operand, rs field nonzero):
  - 1st priority: `mem_reg_write & mem_rd==rs` → mem_result.
  - 2nd priority: `wb_reg_write & wb_rd==rs` → wb_result.
  - Otherwise the registered value.
  - rs==0 → forwarded value is the registered value, which is 0 from the register file.
- Operand outputs:
  - `ex_alu_a = src_a_pc ? pc : fwd_rs1`.
  - `ex_alu_b = src_b_imm ? imm : fwd_rs2`.
  - `ex_store_data = fwd_rs2`.
- ex_reg_write, ex_mem_read, ex_mem_write come straight from registers; they are zero whenever valid=0 by construction.

## Timing
- Latency: ID fields appear on ex_* one cycle after capture.
- Operands are combinational from registers plus the mem_*/wb_* inputs in the same cycle.
- stall_id is combinational and asserts in the same cycle the hazard is present in ID.
- A load-use pair costs exactly one bubble:
  - Cycle n: load in EX, consumer in ID, stall_id=1.
  - Cycle n+1: bubble in EX, load in MEM.
  - Cycle n+2: consumer in EX, load in WB; value arrives via the wb forward.
- flush and stall_id in the same cycle: flush wins, stall_id=0, bubble loaded.
- Reset (async assert, any cycle including mid-stall): all registers 0 immediately. Outputs then read ex_valid=0, ex_pc=0, ex_rd=0, ex_alu_op=0, ex_alu_a=0, ex_alu_b=0, ex_store_data=0, all control 0, stall_id=0.
- Release is synchronous-safe: the first capture happens on the first rising edge after rst_n high.

## Test plan
- Reset: assert rst_n=0 mid-operation → all ex_* and stall_id read 0 with no clock edge. Release; ID add with rs1_data=5, rs2_data=7 → next cycle ex_alu_a=5, ex_alu_b=7, ex_alu_op=0000.
- EX/MEM forward: EX holds add with rs1=3 and stale rs1_val=1; mem_reg_write=1, mem_rd=3, mem_result=0x10, wb_rd=3, wb_result=0x20 → ex_alu_a=0x10 (MEM priority). Repeat with rs1=0 → ex_alu_a=0.
- Load-use: lw x5 in EX, ID `add x6,x5,x1` → stall_id=1 and a bubble next cycle (ex_valid=0). Two cycles later the add is in EX with wb_rd=5, wb_result=0xABCD → ex_alu_a=0xABCD.
- Flush vs stall: load-use hazard present together with flush=1 → stall_id=0, next ex_valid=0, ex_reg_write=0.
- WB capture bypass: wb writes x9=0x55 in the cycle ID reads x9 (stale 0) → registered rs1_val=0x55, visible as ex_alu_a with no mem/wb forwarding active.
- Operand selects: id_src_a_pc=1, id_pc=0x100, id_src_b_imm=1, id_imm=0xFFFFF800, rs2 forwarded 0x77 → ex_alu_a=0x100, ex_alu_b=0xFFFFF800, ex_store_data=0x77.
